// File: rtl/dbg_wb_pkg.sv
// Shared op codes, FSM state type and reset constants for the debug Wishbone command engine.
package dbg_wb_pkg;

    localparam logic [1:0] OP_SETADDR = 2'b00;
    localparam logic [1:0] OP_SETCTRL = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    localparam logic [3:0] DEFAULT_SEL = 4'hF;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBus  = 2'b01,
        StResp = 2'b10
    } state_e;

endpackage

// File: rtl/dbg_wb_timeout.sv
// Bus-access watchdog: cleared when a command is accepted, counts stalled cycles,
// and flags the terminal count TIMEOUT-1.
module dbg_wb_timeout #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && !tc) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign tc = (count_q == TERMINAL);

endmodule

// File: rtl/dbg_wb_cmd_master.sv
// Debug command engine: turns SETADDR/SETCTRL/WRITE/READ commands into single Wishbone
// cycles with optional address auto-increment and a bus timeout.
module dbg_wb_cmd_master
    import dbg_wb_pkg::*;
#(
    parameter int unsigned AWIDTH  = 32,
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DWIDTH-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_data,
    output logic              rsp_err,
    output logic [AWIDTH-1:0] addr_o,
    output logic [DWIDTH-1:0] data_o,
    input  logic [DWIDTH-1:0] data_i,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [3:0]        sel_o,
    input  logic              ack_i
);

    state_e            state_q;
    logic [AWIDTH-1:0] addr_q;
    logic [3:0]        sel_q;
    logic              autoinc_q;
    logic              cyc_q;
    logic              we_q;
    logic [DWIDTH-1:0] wdata_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DWIDTH-1:0] rsp_data_q;

    logic accept;
    logic tc;

    assign cmd_ready = (state_q == StIdle);
    assign accept    = cmd_valid && cmd_ready;

    dbg_wb_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clr  (accept),
        .en   ((state_q == StBus) && !ack_i),
        .tc   (tc)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            sel_q       <= DEFAULT_SEL;
            autoinc_q   <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_SETADDR: addr_q <= {cmd_data[AWIDTH-1:2], 2'b00};
                            OP_SETCTRL: begin
                                sel_q     <= cmd_data[3:0];
                                autoinc_q <= cmd_data[8];
                            end
                            OP_WRITE: begin
                                wdata_q <= cmd_data;
                                we_q    <= 1'b1;
                                cyc_q   <= 1'b1;
                                state_q <= StBus;
                            end
                            OP_READ: begin
                                we_q    <= 1'b0;
                                cyc_q   <= 1'b1;
                                state_q <= StBus;
                            end
                        endcase
                    end
                end
                StBus: begin
                    // ack takes priority over a coincident terminal count
                    if (ack_i) begin
                        cyc_q       <= 1'b0;
                        rsp_data_q  <= we_q ? '0 : data_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        if (autoinc_q) begin
                            addr_q <= addr_q + AWIDTH'(4);
                        end
                        state_q <= StResp;
                    end else if (tc) begin
                        cyc_q       <= 1'b0;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign addr_o    = addr_q;
    assign data_o    = wdata_q;
    assign cyc_o     = cyc_q;
    assign stb_o     = cyc_q;
    assign we_o      = we_q;
    assign sel_o     = sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_dbg_wb_cmd_master.sv
// Directed bench for dbg_wb_cmd_master with TIMEOUT=8; stimulus and sampling on the falling edge.
module tb_dbg_wb_cmd_master;

    localparam logic [1:0] OP_SETADDR = 2'b00;
    localparam logic [1:0] OP_SETCTRL = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic [31:0] data_i = 32'h0BAD_0BAD;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [3:0]  sel_o;
    logic        ack_i = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dbg_wb_cmd_master #(
        .AWIDTH (32),
        .DWIDTH (32),
        .TIMEOUT(8)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .addr_o   (addr_o),
        .data_o   (data_o),
        .data_i   (data_i),
        .cyc_o    (cyc_o),
        .stb_o    (stb_o),
        .we_o     (we_o),
        .sel_o    (sel_o),
        .ack_i    (ack_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one command for one cycle; returns at the falling edge after acceptance.
    task automatic send(input logic [1:0] op, input logic [31:0] data);
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Let stb sit for 'waits' cycles, then ack for one cycle with read data.
    task automatic bus_ack(input int waits, input logic [31:0] rdata);
        repeat (waits) @(negedge clk);
        data_i = rdata;
        ack_i  = 1'b1;
        @(negedge clk);
        ack_i  = 1'b0;
        data_i = 32'h0BAD_0BAD;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [31:0] exp_addr,
                           input logic [31:0] rdata);
        send(OP_READ, 32'h0);
        check({tag, "_addr"}, addr_o, exp_addr);
        check({tag, "_we"}, {31'b0, we_o}, 32'd0);
        bus_ack(0, rdata);
        check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
        check({tag, "_rsp_data"}, rsp_data, rdata);
        check({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
        consume();
    endtask

    initial begin
        int n;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_addr", addr_o, 32'h0);
        check("rst_sel", {28'b0, sel_o}, 32'hF);
        check("rst_cyc", {31'b0, cyc_o}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_data_o", data_o, 32'h0);

        // ack outside BUS must be ignored
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
        check("idle_ack_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("idle_ack_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        // SETADDR with low bits set: aligned, no response
        send(OP_SETADDR, 32'h0000_1003);
        check("setaddr_addr", addr_o, 32'h0000_1000);
        check("setaddr_no_rsp", {31'b0, rsp_valid}, 32'd0);
        check("setaddr_ready", {31'b0, cmd_ready}, 32'd1);

        // WRITE, ack after 2 stalled cycles
        send(OP_WRITE, 32'hCAFE_F00D);
        check("wr_stb", {31'b0, stb_o}, 32'd1);
        check("wr_cyc", {31'b0, cyc_o}, 32'd1);
        check("wr_we", {31'b0, we_o}, 32'd1);
        check("wr_addr", addr_o, 32'h0000_1000);
        check("wr_data_o", data_o, 32'hCAFE_F00D);
        check("wr_sel", {28'b0, sel_o}, 32'hF);
        check("wr_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        bus_ack(2, 32'h1234_5678);
        check("wr_stb_drop", {31'b0, stb_o}, 32'd0);
        check("wr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("wr_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("wr_rsp_data", rsp_data, 32'h0);
        check("wr_no_autoinc", addr_o, 32'h0000_1000);
        consume();
        check("wr_done_valid", {31'b0, rsp_valid}, 32'd0);
        check("wr_done_ready", {31'b0, cmd_ready}, 32'd1);

        // SETCTRL: sel F, autoinc on; three reads
        send(OP_SETCTRL, 32'h0000_010F);
        check("setctrl_sel", {28'b0, sel_o}, 32'hF);
        do_read("rd1", 32'h0000_1000, 32'd1);
        do_read("rd2", 32'h0000_1004, 32'd2);
        do_read("rd3", 32'h0000_1008, 32'd3);
        check("rd3_next_addr", addr_o, 32'h0000_100C);

        // Address wrap
        send(OP_SETADDR, 32'hFFFF_FFFC);
        do_read("wrap1", 32'hFFFF_FFFC, 32'hA5A5_0001);
        do_read("wrap2", 32'h0000_0000, 32'hA5A5_0002);

        // Ack coincident with terminal count: normal completion
        send(OP_SETADDR, 32'h0000_3000);
        send(OP_READ, 32'h0);
        bus_ack(7, 32'h7777_0007);
        check("tc_ack_err", {31'b0, rsp_err}, 32'd0);
        check("tc_ack_data", rsp_data, 32'h7777_0007);
        check("tc_ack_addr", addr_o, 32'h0000_3004);
        consume();

        // Timeout: no ack, stb held TIMEOUT cycles
        send(OP_SETADDR, 32'h0000_2000);
        data_i = 32'hDEAD_BEEF;
        send(OP_READ, 32'h0);
        n = 0;
        while (stb_o && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("to_stb_cycles", n, 32'd8);
        check("to_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("to_rsp_err", {31'b0, rsp_err}, 32'd1);
        check("to_rsp_data", rsp_data, 32'h0);
        check("to_addr", addr_o, 32'h0000_2000);
        consume();

        // Response back-pressure for 5 cycles
        send(OP_READ, 32'h0);
        bus_ack(0, 32'h55AA_33CC);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("bp_rsp_data", rsp_data, 32'h55AA_33CC);
            check("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        consume();
        check("bp_done_ready", {31'b0, cmd_ready}, 32'd1);

        // Reset in the middle of a bus access
        send(OP_READ, 32'h0);
        check("mid_stb_before", {31'b0, stb_o}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_cyc", {31'b0, cyc_o}, 32'd0);
        check("mid_rst_stb", {31'b0, stb_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", {31'b0, cmd_ready}, 32'd1);
        check("mid_rst_addr", addr_o, 32'h0);
        check("mid_rst_sel", {28'b0, sel_o}, 32'hF);
        check("mid_rst_rsp", {31'b0, rsp_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
